// File: rtl/system1_onchip_memory_pipe_pkg.sv
// Shared types and constants for the on-chip RAM slave: controller states,
// legal read-latency range and the byte-lane width helper.
package system1_onchip_mem_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/system1_onchip_memory_pipe_if.sv
// Pipelined Avalon-MM slave bundle (waitrequest / readdatavalid) plus init_done.
interface system1_onchip_memory_pipe_if
    import system1_onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]           address;
    logic [be_width(DATA_WIDTH)-1:0] byteenable;
    logic                            chipselect;
    logic                            read;
    logic                            write;
    logic [DATA_WIDTH-1:0]           writedata;
    logic                            clken;
    logic [DATA_WIDTH-1:0]           readdata;
    logic                            readdatavalid;
    logic                            waitrequest;
    logic                            init_done;

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata, clken,
        output readdata, readdatavalid, waitrequest, init_done
    );

    modport master (
        output address, byteenable, chipselect, read, write, writedata, clken,
        input  readdata, readdatavalid, waitrequest, init_done
    );
endinterface

// File: rtl/system1_onchip_memory_pipe_ram_sp.sv
// Inferred single-port RAM: byte-enabled writes, registered read address,
// asynchronous read of the registered address. No control logic here.
module system1_onchip_mem_ram_sp
    import system1_onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 51200,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic                            re,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [be_width(DATA_WIDTH)-1:0] be,
    input  logic [DATA_WIDTH-1:0]           wdata,
    output logic [DATA_WIDTH-1:0]           q
);
    localparam int BE_W = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) addr_q <= addr;
    end

    // Reading through the registered address gives write-then-read forwarding for free.
    assign q = mem[addr_q];

endmodule

// File: rtl/system1_onchip_memory_pipe.sv
// On-chip RAM slave: post-reset clear sequencer, bus/clear port mux, range check
// and a 1- or 2-cycle pipelined read return path.
module system1_onchip_memory_pipe
    import system1_onchip_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 51200,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    READ_LATENCY   = 2,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic clk,
    input logic reset_n,
    system1_onchip_memory_pipe_if.slave bus
);
    localparam int BE_W   = be_width(DATA_WIDTH);
    localparam int RAM_AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    state_t            state, state_nxt;
    logic [RAM_AW-1:0] clr_cnt;
    logic              clr_last;

    assign clr_last = (clr_cnt == RAM_AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + RAM_AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RESET: state_nxt = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ST_CLEAR: if (clr_last) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_RESET;
        endcase
    end

    logic ready, wait_req, accept, rd_acc, wr_acc, in_range;

    assign ready    = (state == ST_READY);
    assign wait_req = ~ready | ~bus.clken;
    assign accept   = bus.chipselect & (bus.read | bus.write) & ~wait_req;
    // A simultaneous read+write is a write only.
    assign wr_acc   = accept & bus.write;
    assign rd_acc   = accept & bus.read & ~bus.write;
    assign in_range = {1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH);

    assign bus.waitrequest = wait_req;
    assign bus.init_done   = ready;

    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [BE_W-1:0]       ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = in_range ? bus.address[RAM_AW-1:0] : '0;
        ram_be    = bus.byteenable;
        ram_wdata = bus.writedata;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_be    = '1;
            ram_wdata = CLEAR_VALUE;
        end else if (wr_acc && in_range) begin
            ram_we = 1'b1;
        end
    end

    system1_onchip_mem_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (rd_acc),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // vld_pipe[0] marks RAM data ready; the top bit is the bus-visible valid.
    logic [READ_LATENCY-1:0] vld_pipe;
    logic                    rng_q;
    logic [DATA_WIDTH-1:0]   ram_data, rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rng_q    <= 1'b0;
        end else begin
            vld_pipe <= READ_LATENCY'({vld_pipe, rd_acc});
            if (rd_acc) rng_q <= in_range;
        end
    end

    assign ram_data = rng_q ? ram_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         rdata_q <= '0;
        else if (vld_pipe[0]) rdata_q <= ram_data;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        assign bus.readdata = rdata_q;
    end else begin : g_lat1
        // rdata_q keeps readdata stable between pulses.
        assign bus.readdata = vld_pipe[0] ? ram_data : rdata_q;
    end

    assign bus.readdatavalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_system1_onchip_memory_pipe.sv
// Bench for system1_onchip_memory_pipe: table vectors, directed multi-cycle
// sequences and random traffic against a word-array / due-cycle queue model.
module tb_system1_onchip_memory_pipe;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam int          AW    = 16;
    localparam int          RL    = 2;
    localparam logic [31:0] CV    = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    system1_onchip_memory_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    system1_onchip_memory_pipe #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0, failures = 0;
    int edge_n = 0, rel = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd = '0;

    typedef struct { int due; logic [31:0] data; } exp_t;
    typedef struct { int at;  logic [31:0] data; } obs_t;
    exp_t exp_q[$];
    obs_t log_q[$];

    typedef struct {
        bit rd; bit wr; int addr; logic [3:0] be; logic [31:0] wd;
        int nvld; logic [31:0] exp;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit ready_m();
        return rel >= DEPTH + 1;
    endfunction

    task automatic idle();
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = '0; bus.byteenable = '0; bus.writedata = '0; bus.clken = 1'b1;
    endtask

    task automatic drive(input bit rd, input bit wr, input int addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.chipselect = 1'b1; bus.read = rd; bus.write = wr;
        bus.address = AW'(addr); bus.byteenable = be; bus.writedata = wd;
    endtask

    // One clock: update the model from the inputs at the edge, then check outputs.
    task automatic tick();
        bit acc, exp_v;
        int a;
        exp_t e;
        acc = reset_n && ready_m() && bus.clken && bus.chipselect && (bus.read || bus.write);
        a   = int'(bus.address);
        @(posedge clk);
        edge_n++;
        if (acc && bus.write) begin
            if (a < DEPTH)
                for (int i = 0; i < 4; i++)
                    if (bus.byteenable[i]) mem_m[a][i*8 +: 8] = bus.writedata[i*8 +: 8];
        end else if (acc) begin
            e.due  = edge_n + RL - 1;
            e.data = (a < DEPTH) ? mem_m[a] : 32'h0;
            exp_q.push_back(e);
        end
        if (reset_n) rel++;
        #1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        if (exp_v) begin
            last_rd = exp_q[0].data;
            exp_q.delete(0);
        end
        chk("rdvalid", 32'(bus.readdatavalid), 32'(exp_v));
        chk("readdata", bus.readdata, last_rd);
        chk("waitrequest", 32'(bus.waitrequest), 32'(!(ready_m() && bus.clken)));
        chk("init_done", 32'(bus.init_done), 32'(ready_m()));
        if (bus.readdatavalid) log_q.push_back('{at: edge_n, data: bus.readdata});
    endtask

    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        idle();
        #1;
        exp_q.delete();
        log_q.delete();
        rel = 0;
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
        chk("rst_rdvalid", 32'(bus.readdatavalid), 32'h0);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_waitrequest", 32'(bus.waitrequest), 32'h1);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        repeat (hold) tick();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_clear();
        int n = 0;
        for (int i = 0; i < 40 && !bus.init_done; i++) begin
            n++;
            tick();
        end
        chk("clear_wait_cycles", 32'(n), 32'(DEPTH + 1));
    endtask

    task automatic read_all_clear(input string name);
        log_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, a, 4'h0, 32'h0);
            tick();
        end
        idle();
        repeat (4) tick();
        chk({name, "_count"}, 32'(log_q.size()), 32'(DEPTH));
        for (int i = 0; i < log_q.size() && i < DEPTH; i++)
            chk($sformatf("%s_data%0d", name, i), log_q[i].data, CV);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc, n;
        vt[0]  = '{rd:0, wr:1, addr:5,  be:4'hF, wd:32'h11223344, nvld:0, exp:32'h0};
        vt[1]  = '{rd:0, wr:1, addr:5,  be:4'h5, wd:32'hAABBCCDD, nvld:0, exp:32'h0};
        vt[2]  = '{rd:1, wr:0, addr:5,  be:4'h0, wd:32'h0,        nvld:1, exp:32'h11BB33DD};
        vt[3]  = '{rd:0, wr:1, addr:20, be:4'hF, wd:32'h55,       nvld:0, exp:32'h0};
        vt[4]  = '{rd:1, wr:0, addr:20, be:4'h0, wd:32'h0,        nvld:1, exp:32'h0};
        vt[5]  = '{rd:1, wr:1, addr:3,  be:4'hF, wd:32'h77,       nvld:0, exp:32'h0};
        vt[6]  = '{rd:1, wr:0, addr:3,  be:4'h0, wd:32'h0,        nvld:1, exp:32'h77};
        vt[7]  = '{rd:1, wr:0, addr:0,  be:4'h0, wd:32'h0,        nvld:1, exp:CV};
        vt[8]  = '{rd:1, wr:0, addr:4,  be:4'h0, wd:32'h0,        nvld:1, exp:CV};
        vt[9]  = '{rd:0, wr:1, addr:15, be:4'h0, wd:32'h12345678, nvld:0, exp:32'h0};
        vt[10] = '{rd:1, wr:0, addr:15, be:4'h0, wd:32'h0,        nvld:1, exp:CV};
        vt[11] = '{rd:1, wr:0, addr:16, be:4'h0, wd:32'h0,        nvld:1, exp:32'h0};

        // Clear after reset, then every word reads back as the clear value.
        idle();
        do_reset(3);
        wait_clear();
        read_all_clear("clear");

        // Table vectors: byte enables, out-of-range, dual request, empty byteenable.
        for (int v = 0; v < 12; v++) begin
            log_q.delete();
            drive(vt[v].rd, vt[v].wr, vt[v].addr, vt[v].be, vt[v].wd);
            tick();
            idle();
            repeat (3) tick();
            chk($sformatf("vec%0d_nvld", v), 32'(log_q.size()), 32'(vt[v].nvld));
            if (vt[v].nvld == 1 && log_q.size() == 1)
                chk($sformatf("vec%0d_data", v), log_q[0].data, vt[v].exp);
        end

        // Back-to-back: 8 writes, then 8 reads in consecutive cycles.
        for (int a = 0; a < 8; a++) begin
            drive(0, 1, a, 4'hF, 32'(a));
            tick();
        end
        log_q.delete();
        first_acc = 0;
        for (int a = 0; a < 8; a++) begin
            drive(1, 0, a, 4'h0, 32'h0);
            tick();
            if (a == 0) first_acc = edge_n;
        end
        idle();
        repeat (4) tick();
        chk("b2b_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < log_q.size() && i < 8; i++) begin
            chk($sformatf("b2b_data%0d", i), log_q[i].data, 32'(i));
            chk($sformatf("b2b_edge%0d", i), 32'(log_q[i].at), 32'(first_acc + 1 + i));
        end

        // Read right after a write to the same address sees the new data.
        log_q.delete();
        drive(0, 1, 9, 4'hF, 32'hA5A5_5A5A);
        tick();
        drive(1, 0, 9, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        chk("hazard_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("hazard_data", log_q[0].data, 32'hA5A5_5A5A);

        // clken low for 3 cycles with two reads in flight.
        log_q.delete();
        drive(1, 0, 1, 4'h0, 32'h0);
        tick();
        drive(1, 0, 2, 4'h0, 32'h0);
        tick();
        drive(1, 0, 3, 4'h0, 32'h0);
        bus.clken = 1'b0;
        repeat (3) begin
            tick();
            chk("clken_waitrequest", 32'(bus.waitrequest), 32'h1);
        end
        idle();
        repeat (3) tick();
        chk("clken_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("clken_data0", log_q[0].data, 32'd1);
            chk("clken_data1", log_q[1].data, 32'd2);
        end

        // Reset while a pulse is showing and another read is in flight.
        drive(1, 0, 6, 4'h0, 32'h0);
        tick();
        drive(1, 0, 7, 4'h0, 32'h0);
        tick();
        #2;
        do_reset(2);
        wait_clear();
        chk("reset_dropped_reads", 32'(log_q.size()), 32'd0);
        read_all_clear("reclear");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            n = $urandom_range(0, 2);
            drive(n != 1, n != 0, $urandom_range(0, 19), 4'($urandom), $urandom);
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.clken      = ($urandom_range(0, 7) != 0);
            tick();
        end
        idle();
        repeat (4) tick();
        chk("random_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
